// File: rtl/alu_seq_unit.sv
// Handshaked ALU: single-cycle logic/arith/compare/shift ops; iterative MUL/DIVU/REMU
// over WIDTH cycles are built only when ALU_MULDIV_EN is defined.
module alu_seq_unit #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;

  assign shamt     = b[SHW-1:0];
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLTU: alu_res = (a < b) ? WIDTH'(1) : '0;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam logic [3:0]  OP_MUL   = 4'b1100;
  localparam logic [3:0]  OP_DIVU  = 4'b1101;
  localparam logic [3:0]  OP_REMU  = 4'b1110;
  localparam logic [1:0]  ST_BUSY  = 2'd1;
  localparam int unsigned CW       = SHW + 1;

  logic [3:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc: running product (MUL) or partial remainder (DIV)
  logic [WIDTH-1:0] acc_q, acc_d;
  // opb: multiplicand (shifts left) or divisor; shr: multiplier or dividend/quotient
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] shr_q, shr_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_acc, step_opb, step_shr, step_res;
  logic             is_muldiv;

  assign is_muldiv = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);

  // One iteration; a zero divisor naturally yields all-ones quotient and remainder = a.
  always_comb begin
    trial    = {acc_q, shr_q[WIDTH-1]};
    step_acc = acc_q;
    step_opb = opb_q;
    step_shr = shr_q;
    if (op_q == OP_MUL) begin
      step_acc = acc_q + (shr_q[0] ? opb_q : '0);
      step_opb = opb_q << 1;
      step_shr = shr_q >> 1;
    end else if (trial >= {1'b0, opb_q}) begin
      step_acc = trial[WIDTH-1:0] - opb_q;
      step_shr = {shr_q[WIDTH-2:0], 1'b1};
    end else begin
      step_acc = trial[WIDTH-1:0];
      step_shr = {shr_q[WIDTH-2:0], 1'b0};
    end
    step_res = (op_q == OP_DIVU) ? step_shr : step_acc;
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
`ifdef ALU_MULDIV_EN
    op_d  = op_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opb_d = opb_q;
    shr_d = shr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef ALU_MULDIV_EN
          if (is_muldiv) begin
            op_d    = op;
            cnt_d   = CW'(WIDTH);
            acc_d   = '0;
            opb_d   = b;
            shr_d   = a;
            state_d = ST_BUSY;
          end else begin
            result_d = alu_res;
            state_d  = ST_DONE;
          end
`else
          result_d = alu_res;
          state_d  = ST_DONE;
`endif
        end
      end
`ifdef ALU_MULDIV_EN
      ST_BUSY: begin
        acc_d = step_acc;
        opb_d = step_opb;
        shr_d = step_shr;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = step_res;
          state_d  = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

`ifdef ALU_MULDIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      opb_q <= '0;
      shr_q <= '0;
    end else begin
      op_q  <= op_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opb_q <= opb_d;
      shr_q <= shr_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit (WIDTH=32); expectations follow ALU_MULDIV_EN.
module tb_alu_seq_unit;

`ifdef ALU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  alu_seq_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    case (o)
      4'h0: r = x & y;
      4'h1: r = x | y;
      4'h2: r = x + y;
      4'h3: r = x - y;
      4'h4: r = (x < y) ? 32'd1 : 32'd0;
      4'h5: r = ~(x | y);
      4'h6: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'h7: r = x ^ y;
      4'h8: r = x << y[4:0];
      4'h9: r = x >> y[4:0];
      4'hA: r = 32'($signed(x) >>> y[4:0]);
      4'hC: r = MULDIV ? 32'(x * y) : 32'd0;
      4'hD: r = !MULDIV ? 32'd0 : (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'hE: r = !MULDIV ? 32'd0 : (y == 0) ? x : x % y;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [3:0] o);
    return (MULDIV && (o == 4'hC || o == 4'hD || o == 4'hE)) ? 32 : 0;
  endfunction

  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int hold);
    int lat;
    int exp_lat;
    bit busy_ok;
    bit stable_ok;
    logic [31:0] exp_r;
    logic [31:0] held;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1'b1);
    op = o; a = x; b = y; in_valid = 1'b1;
    exp_q.push_back(model(o, x, y));
    lat_q.push_back(model_lat(o));
    @(posedge clk); #1;
    // Scramble inputs: only the values at acceptance may matter.
    in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    lat = 0; busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    exp_r   = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    chk($sformatf("latency_op%0h", o), 64'(lat), 64'(exp_lat));
    chk("in_ready_busy", busy_ok, 1'b1);
    chk($sformatf("result_op%0h", o), result, exp_r);
    chk("zero", zero, exp_r == 32'd0);
    $display("txn op=%h a=%h b=%h result=%h exp=%h cycles=%0d", o, x, y, result, exp_r, lat);
    held = result; stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); in_valid = 1'b1;
      @(posedge clk); #1;
      if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable_ok = 1'b0;
    end
    if (hold > 0) chk("backpressure_stable", stable_ok, 1'b1);
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_hs", in_ready, 1'b1);
    chk("out_valid_after_hs", out_valid, 1'b0);
    @(negedge clk); out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", zero, 1'b1);
    @(negedge clk); rst_n = 1'b1;

    do_op(4'h2, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'h6, 32'hFFFF_FFFE, 32'd1, 0);
    do_op(4'h4, 32'hFFFF_FFFE, 32'd1, 0);
    do_op(4'hA, 32'h8000_0000, 32'h24, 0);
    do_op(4'hC, 32'h0001_2345, 32'h0001_0000, 0);
    do_op(4'hD, 32'd100, 32'd7, 0);
    do_op(4'hE, 32'd100, 32'd7, 0);
    do_op(4'hD, 32'd5, 32'd0, 0);
    do_op(4'hE, 32'd5, 32'd0, 0);
    do_op(4'h0, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    do_op(4'h1, 32'hF000_0001, 32'h0000_1230, 0);
    do_op(4'h3, 32'd3, 32'd5, 0);
    do_op(4'h5, 32'h0F0F_0000, 32'h0000_00FF, 0);
    do_op(4'h8, 32'h0000_0003, 32'h0000_003F, 0);
    do_op(4'h9, 32'h8000_0010, 32'h0000_0004, 0);
    do_op(4'hB, 32'h1234_5678, 32'd1, 0);
    do_op(4'hF, 32'h1234_5678, 32'd1, 0);
    do_op(4'h7, 32'hDEAD_BEEF, 32'h1234_5678, 10);
    do_op(4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
    for (int i = 0; i < 24; i++) do_op(4'($urandom), $urandom, $urandom, 0);

    // Reset in the middle of a DIVU.
    @(negedge clk);
    op = 4'hD; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_result", result, 32'd0);
    chk("midrst_zero", zero, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    do_op(4'hD, 32'd100, 32'd7, 0);
    do_op(4'h2, 32'd40, 32'd2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
